ahb_decoder_mux: RTL
====================

Name: ahb_decoder_mux

Overview:
Parametrised AHB-Lite address decoder and response multiplexer for an N-slave bus segment. Each slave has its own base/mask region. The block registers the data-phase slave selection and multiplexes HREADY/HRESP/HRDATA back to the master. A built-in default slave returns a two-cycle ERROR to unmapped NONSEQ/SEQ transfers. It sits between the single AHB-Lite master and the slave array, replacing the fixed 2-slave top-bits decoder.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HRDATA width
SLV_BASE, {32'h9000_0000,32'h8000_0000,32'h4000_0000,32'h0000_0000}, flat base vector; slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
SLV_MASK, {32'hF000_0000,32'hF000_0000,32'hC000_0000,32'hC000_0000}, flat mask vector, same packing
ERR_CNT_WIDTH, 8, width of saturating decode-error counter

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HADDR  input  ADDR_WIDTH  address-phase address
HTRANS  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
HREADYOUT_S  input  NUM_SLAVES  per-slave HREADYOUT
HRESP_S  input  NUM_SLAVES  per-slave HRESP (1 = ERROR)
HRDATA_S  input  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
HSEL  output  NUM_SLAVES  one-hot address-phase slave select
HREADY  output  1  muxed ready to master and all slaves
HRESP  output  1  muxed response to master
HRDATA  output  DATA_WIDTH  muxed read data to master
decode_err  output  1  one-cycle pulse on each unmapped transfer (first ERROR cycle)
err_count  output  ERR_CNT_WIDTH  saturating count of unmapped transfers

Behaviour:
- One clock HCLK; reset HRESETn asynchronous, active-low. All state clears immediately on assertion.
- Reset values: sel_dp = 0, state = DS_IDLE, err_count = 0. Outputs: HSEL = 0, HREADY = 1, HRESP = 0, HRDATA = 0, decode_err = 0.
- Address decode (combinational): match_i = ((HADDR & MASK_i) == BASE_i).
  - HSEL[i] = match_i and no match_j for j < i; the lowest index wins on overlap.
  - HSEL = 0 when nothing matches or HRESETn is low.
  - MASK_i = 0 with BASE_i = 0 makes slave i a catch-all.
- Data-phase register sel_dp (NUM_SLAVES bits): loads HSEL on every rising HCLK with HREADY = 1; holds while HREADY = 0.
- Response mux, when sel_dp has bit i set:
  - HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i], HRDATA = slice i.
  - Zero added latency; purely combinational from sel_dp.
- Default slave FSM (active when sel_dp = 0); HRDATA = 0 in all states:
  - DS_IDLE: HREADY = 1, HRESP = 0.
  - DS_ERR1: HREADY = 0, HRESP = 1, decode_err = 1. Always goes to DS_ERR2 next.
  - DS_ERR2: HREADY = 1, HRESP = 1.
  - Transition into DS_ERR1 from DS_IDLE or DS_ERR2: on a clock edge with HREADY = 1, HSEL = 0 and HTRANS[1] = 1.
  - DS_IDLE or DS_ERR2 go to DS_IDLE on any other accepted address phase, including a mapped slave selection.
  - IDLE/BUSY to unmapped space: OKAY, zero wait, no error, no count.
- Back-to-back: an unmapped transfer accepted during DS_ERR2 re-enters DS_ERR1 (ERROR, ERROR, ERROR, ERROR). A mapped transfer accepted in DS_ERR2 selects that slave next cycle.
- err_count increments by 1 on each entry to DS_ERR1 and saturates at all-ones; no wrap.
- HTRANS is not registered beyond the FSM decision; slaves qualify HSEL with HTRANS themselves.
- Reset mid-transfer (including in DS_ERR1): bus returns to the reset values at once; the in-flight response is abandoned.

Test Plan:
1. Reset: hold HRESETn = 0 with HADDR = 0x4000_0010, HTRANS = NONSEQ -> HSEL = 0, HREADY = 1, HRESP = 0, err_count = 0.
2. Mapped decode: NONSEQ to 0x0000_0100, 0x4000_0000, 0x8000_0004, 0x9FFF_FFFC -> HSEL = 0001, 0010, 0100, 1000.
   - Next cycle HRDATA equals that slave's HRDATA_S slice.
   - Slave 2 holding HREADYOUT_S[2] = 0 for 3 cycles -> HREADY low 3 cycles and sel_dp held.
3. Unmapped: NONSEQ to 0xA000_0000 -> HSEL = 0; next cycle HREADY = 0/HRESP = 1/decode_err = 1, then HREADY = 1/HRESP = 1; err_count = 1.
   - The same address with HTRANS = IDLE -> OKAY zero wait, err_count unchanged.
4. Back-to-back: SEQ to 0xB000_0000 accepted in DS_ERR2, then NONSEQ to 0x4000_0000 -> second ERROR pair, err_count += 1.
   - Slave 1 is then muxed in the following data phase.
5. Overlap and saturation:
   - Override SLV_BASE/MASK so slaves 0 and 3 both match 0x1000_0000 -> HSEL = 0001.
   - 300 unmapped transfers with ERR_CNT_WIDTH = 8 -> err_count = 255.
6. Async reset asserted during DS_ERR1 -> HREADY = 1 and HRESP = 0 immediately, before the next HCLK edge; state = DS_IDLE after release.

Source files
------------

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer for an N-slave segment.
// Unmapped NONSEQ/SEQ transfers are answered by a built-in two-cycle ERROR slave.
module ahb_decoder_mux #(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h9000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hC000_0000},
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [ADDR_WIDTH-1:0]          HADDR,
    input  logic [1:0]                     HTRANS,
    input  logic [NUM_SLAVES-1:0]          HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]          HRESP_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    output logic [NUM_SLAVES-1:0]          HSEL,
    output logic                           HREADY,
    output logic                           HRESP,
    output logic [DATA_WIDTH-1:0]          HRDATA,
    output logic                           decode_err,
    output logic [ERR_CNT_WIDTH-1:0]       err_count
);

    typedef enum logic [1:0] {DsIdle, DsErr1, DsErr2} ds_state_e;

    ds_state_e             state;
    logic [NUM_SLAVES-1:0] sel_dp;
    logic                  found;
    logic                  htrans_active;

    assign htrans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

    // Priority decode: the lowest matching index wins on overlapping regions.
    always_comb begin
        HSEL  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found &&
                ((HADDR & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                HSEL[i] = 1'b1;
                found   = 1'b1;
            end
        end
        if (!HRESETn) begin
            HSEL = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_dp <= '0;
        end else if (HREADY) begin
            sel_dp <= HSEL;
        end
    end

    // Default slave; it only leaves DsIdle when sel_dp is being loaded with zero.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= DsIdle;
            err_count <= '0;
        end else begin
            unique case (state)
                DsErr1: state <= DsErr2;
                default: begin
                    if (HREADY) begin
                        if ((HSEL == '0) && htrans_active) begin
                            state <= DsErr1;
                            if (err_count != '1) begin
                                err_count <= err_count + ERR_CNT_WIDTH'(1);
                            end
                        end else begin
                            state <= DsIdle;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (sel_dp == '0) begin
            unique case (state)
                DsErr1: begin
                    HREADY = 1'b0;
                    HRESP  = 1'b1;
                end
                DsErr2: begin
                    HREADY = 1'b1;
                    HRESP  = 1'b1;
                end
                default: begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
            endcase
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (sel_dp[i]) begin
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                    HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign decode_err = (state == DsErr1) && (sel_dp == '0);

endmodule
